lc3_mem_arbiter: RTL and testbench

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

---
 rtl/lc3_mem_arbiter_pkg.sv | 23 ++
 rtl/lc3_mem_arbiter_if.sv | 51 +++++
 rtl/lc3_wait_counter.sv | 35 +++
 rtl/lc3_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_arbiter_pkg
// Brief    : Shared state/owner encodings for the LC-3 memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_mem_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/lc3_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_arbiter_if
// Brief    : CPU / IO requester and memory-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface lc3_mem_arbiter_if;
    import lc3_mem_arbiter_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_grant;
    logic              cpu_done;

    logic              io_req;
    logic              io_we;
    logic [DATA_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_grant;
    logic              io_done;

    logic [DATA_W-1:0] rdata;
    logic              err;

    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata, mem_ready,
        output cpu_grant, cpu_done, io_grant, io_done,
        output rdata, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata, mem_ready,
        input  cpu_grant, cpu_done, io_grant, io_done,
        input  rdata, err, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/lc3_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : lc3_wait_counter
// Brief    : Counts ACCESS cycles; o_expired flags the TIMEOUT-th cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_wait_counter #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    output logic      o_expired
);

    localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    // Count is zero in the first ACCESS cycle, so c_LAST marks the TIMEOUT-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_en) begin
            r_count <= '0;
        end else if (r_count != c_LAST) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign o_expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_arbiter
// Brief    : Two-requester (CPU, IO) memory arbiter with starvation guard and
//            access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter
    import lc3_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    lc3_mem_arbiter_if.slave  bus
);

    localparam int              c_SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    state_t            r_state;
    owner_t            r_owner;
    logic [c_SW-1:0]   r_starve;
    logic              r_cpu_grant, r_io_grant, r_cpu_done, r_io_done;
    logic              r_mem_en, r_mem_we, r_err;
    logic [DATA_W-1:0] r_mem_addr, r_mem_wdata, r_rdata;
    logic              w_expired;
    logic              w_pick_cpu;

    lc3_wait_counter #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == ST_ACCESS),
        .o_expired (w_expired)
    );

    // CPU wins ties until it has starved IO for STARVE_LIMIT grants.
    assign w_pick_cpu = bus.cpu_req && (!bus.io_req || (r_starve != c_STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_CPU;
            r_starve    <= '0;
            r_cpu_grant <= 1'b0;
            r_io_grant  <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_io_done   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_cpu_grant <= 1'b0;
            r_io_grant  <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_io_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_req || bus.io_req) begin
                        r_state  <= ST_ACCESS;
                        r_mem_en <= 1'b1;
                        if (w_pick_cpu) begin
                            r_owner     <= OWN_CPU;
                            r_cpu_grant <= 1'b1;
                            r_mem_we    <= bus.cpu_we;
                            r_mem_addr  <= bus.cpu_addr;
                            r_mem_wdata <= bus.cpu_wdata;
                            if (!bus.io_req) begin
                                r_starve <= '0;
                            end else if (r_starve != c_STARVE_MAX) begin
                                r_starve <= r_starve + c_SW'(1);
                            end
                        end else begin
                            r_owner     <= OWN_IO;
                            r_io_grant  <= 1'b1;
                            r_mem_we    <= bus.io_we;
                            r_mem_addr  <= bus.io_addr;
                            r_mem_wdata <= bus.io_wdata;
                            r_starve    <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ready || w_expired) begin
                        r_state    <= ST_DONE;
                        r_mem_en   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_rdata    <= bus.mem_ready ? bus.mem_rdata : '0;
                        r_err      <= !bus.mem_ready;
                        r_cpu_done <= (r_owner == OWN_CPU);
                        r_io_done  <= (r_owner == OWN_IO);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_grant = r_cpu_grant;
    assign bus.io_grant  = r_io_grant;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.io_done   = r_io_done;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_arbiter
// Brief    : Directed table-driven bench for lc3_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    typedef struct {
        logic        cpu;
        logic        we_c;
        logic [15:0] addr_c;
        logic [15:0] wdata_c;
        logic        io;
        logic        we_i;
        logic [15:0] addr_i;
        logic [15:0] wdata_i;
        int          delay;     // ACCESS cycles without mem_ready before it rises
        logic [15:0] mrd;
        logic        exp_io;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errs  = 0;
    int   checks = 0;
    int   overlap = 0;
    vec_t vecs[7];

    lc3_mem_arbiter_if bus ();

    lc3_mem_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((bus.cpu_grant && bus.io_grant) || (bus.cpu_done && bus.io_done))
            overlap++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drop_all();
        bus.cpu_req   = 1'b0;
        bus.io_req    = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    // Waits (bounded) for any of {io_done, cpu_done, io_grant, cpu_grant} in mask.
    task automatic wait_any(input logic [3:0] mask, output logic [3:0] seen);
        int n;
        n = 0;
        seen = 4'b0;
        while (seen == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
            seen = mask & {bus.io_done, bus.cpu_done, bus.io_grant, bus.cpu_grant};
        end
    endtask

    task automatic do_txn(input int id, input vec_t v);
        int          n;
        int          acc;
        logic        got;
        logic        unstable;
        logic [15:0] ea, ed;
        logic        ew;
        bus.cpu_req   = v.cpu;
        bus.cpu_we    = v.we_c;
        bus.cpu_addr  = v.addr_c;
        bus.cpu_wdata = v.wdata_c;
        bus.io_req    = v.io;
        bus.io_we     = v.we_i;
        bus.io_addr   = v.addr_i;
        bus.io_wdata  = v.wdata_i;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = v.mrd;
        ea = v.exp_io ? v.addr_i  : v.addr_c;
        ed = v.exp_io ? v.wdata_i : v.wdata_c;
        ew = v.exp_io ? v.we_i    : v.we_c;
        n = 0;
        got = 1'b0;
        while (!got && n < 5) begin
            @(negedge clk);
            n++;
            got = bus.cpu_grant | bus.io_grant;
        end
        chk($sformatf("v%0d grant_latency", id), n, 1);
        chk($sformatf("v%0d grant_owner", id), {bus.io_grant, bus.cpu_grant}, v.exp_io ? 2'b10 : 2'b01);
        chk($sformatf("v%0d mem_en", id), bus.mem_en, 1'b1);
        chk($sformatf("v%0d mem_we", id), bus.mem_we, ew);
        chk($sformatf("v%0d mem_addr", id), bus.mem_addr, ea);
        chk($sformatf("v%0d mem_wdata", id), bus.mem_wdata, ed);
        acc = 0;
        got = 1'b0;
        unstable = 1'b0;
        while (!got && acc < 40) begin
            acc++;
            bus.mem_ready = (acc > v.delay);
            @(negedge clk);
            got = bus.cpu_done | bus.io_done;
            if (!got && (bus.mem_addr !== ea || bus.mem_wdata !== ed ||
                         bus.mem_en !== 1'b1 || bus.mem_we !== ew || bus.cpu_grant || bus.io_grant))
                unstable = 1'b1;
        end
        chk($sformatf("v%0d access_cycles", id), acc, v.exp_acc);
        chk($sformatf("v%0d access_stable", id), unstable, 1'b0);
        chk($sformatf("v%0d done_owner", id), {bus.io_done, bus.cpu_done}, v.exp_io ? 2'b10 : 2'b01);
        chk($sformatf("v%0d rdata", id), bus.rdata, v.exp_rdata);
        chk($sformatf("v%0d err", id), bus.err, v.exp_err);
        chk($sformatf("v%0d mem_en_done", id), bus.mem_en, 1'b0);
        drop_all();
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_width", id), {bus.io_done, bus.cpu_done}, 2'b00);
    endtask

    initial begin
        logic [3:0] seen;
        int         k;
        int         cyc;
        int         nd;
        vec_t       rv;

        //          cpu  we    addr      wdata     io    we    addr      wdata     dly mrd       exp_io rdata   err   acc
        vecs[0] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'hABCD, 1'b0, 16'hABCD, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFE06, 16'h1234, 2,  16'h5555, 1'b1, 16'h5555, 1'b0, 3};
        vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 16'h0000, 1,  16'h0F0F, 1'b0, 16'h0F0F, 1'b0, 2};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h4000, 16'h0000, 0,  16'h1357, 1'b1, 16'h1357, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b0, 16'h1111, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 99, 16'h7E7E, 1'b0, 16'h0000, 1'b1, 15};
        vecs[5] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 1'b1, 16'h2001, 16'hC0DE, 0,  16'h2468, 1'b0, 16'h2468, 1'b0, 1};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0000, 4,  16'h8001, 1'b1, 16'h8001, 1'b0, 5};

        drop_all();
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.io_we  = 1'b0; bus.io_addr  = '0; bus.io_wdata  = '0;
        bus.mem_rdata = '0;

        // Reset state
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_pulses", {bus.cpu_grant, bus.io_grant, bus.cpu_done, bus.io_done}, 4'b0);
        chk("reset_mem_ctl", {bus.mem_en, bus.mem_we, bus.err}, 3'b0);
        chk("reset_mem_addr", bus.mem_addr, 16'h0000);
        chk("reset_rdata", bus.rdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", {bus.cpu_grant, bus.io_grant, bus.mem_en}, 3'b0);

        for (int i = 0; i < 7; i++) do_txn(i, vecs[i]);

        // Both held continuously, mem_ready stuck high (ignored outside ACCESS).
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
        bus.io_req  = 1'b1; bus.io_we  = 1'b0; bus.io_addr  = 16'h0200;
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h3C3C;
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_grant || bus.io_grant) begin
                chk($sformatf("starve_order%0d", k), {bus.io_grant, bus.cpu_grant},
                    (k % 5 == 4) ? 2'b10 : 2'b01);
                k++;
            end
        end
        chk("starve_grant_count", k, 10);
        drop_all();
        repeat (4) @(negedge clk);

        // Simultaneous requests from starve count 0: CPU first, then IO.
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0300;
        bus.io_req  = 1'b1; bus.io_addr  = 16'h0400;
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h9999;
        wait_any(4'b0011, seen);
        chk("tie_first_grant", seen, 4'b0001);
        wait_any(4'b1110, seen);
        chk("tie_cpu_done_next", seen, 4'b0100);
        bus.cpu_req = 1'b0;
        wait_any(4'b0011, seen);
        chk("tie_second_grant", seen, 4'b0010);
        wait_any(4'b1100, seen);
        chk("tie_io_done", seen, 4'b1000);
        chk("tie_rdata", bus.rdata, 16'h9999);
        drop_all();
        @(negedge clk);

        // Reset in the middle of an access.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h5A5A; bus.cpu_wdata = 16'h7777;
        bus.mem_ready = 1'b0;
        wait_any(4'b0001, seen);
        chk("rst_mid_grant", seen, 4'b0001);
        repeat (3) @(negedge clk);
        chk("rst_mid_in_access", bus.mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_ctl", {bus.mem_en, bus.mem_we, bus.err}, 3'b0);
        chk("rst_mid_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mid_mem_wdata", bus.mem_wdata, 16'h0000);
        chk("rst_mid_rdata", bus.rdata, 16'h0000);
        bus.cpu_req = 1'b0;
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.cpu_done || bus.io_done) nd++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.cpu_done || bus.io_done) nd++;
        end
        chk("rst_mid_no_done", nd, 0);
        rv = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 2};
        do_txn(7, rv);

        chk("never_both_pulses", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
